// File: rtl/mod_memstage.sv
// Memory stage: passes execute results to writeback, issuing one load or store
// request per instruction and bounding the wait for its response.
module mod_memstage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_opcode,
    input  logic        in_twob,
    input  logic [3:0]  in_regbyte,
    input  logic [3:0]  in_rmbyte,
    input  logic [63:0] in_alu_result,
    input  logic [63:0] in_alu_ext_result,
    input  logic [63:0] in_store_data,
    input  logic        in_sim_end,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [63:0] wb_alu_result,
    output logic [63:0] wb_alu_ext_result,
    output logic [7:0]  wb_opcode,
    output logic        wb_twob_opcode,
    output logic [3:0]  wb_regbyte,
    output logic [3:0]  wb_rmbyte,
    output logic        wb_sim_end,
    output logic        store_memstage_active,
    output logic        mem_error
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_OUT  = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [2:0]       state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic             twob_q, twob_d;
    logic [3:0]       regbyte_q, regbyte_d;
    logic [3:0]       rmbyte_q, rmbyte_d;
    logic [63:0]      alu_q, alu_d;
    logic [63:0]      ext_q, ext_d;
    logic [63:0]      sdata_q, sdata_d;
    logic             sim_end_q, sim_end_d;
    logic             is_load_q, is_load_d;
    logic             is_store_q, is_store_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_error_q, mem_error_d;
    logic             timeout_q, timeout_d;

    logic             in_is_load;
    logic             in_is_store;
    logic [CNT_W-1:0] cnt_inc;

    assign in_is_load  = !in_twob && (in_opcode == 8'd139 || in_opcode == 8'd195 ||
                         (in_opcode >= 8'd88 && in_opcode <= 8'd95));
    assign in_is_store = !in_twob && (in_opcode == 8'd137 || in_opcode == 8'd232 ||
                         in_opcode == 8'd255 || (in_opcode >= 8'd80 && in_opcode <= 8'd87));
    assign cnt_inc     = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        twob_d      = twob_q;
        regbyte_d   = regbyte_q;
        rmbyte_d    = rmbyte_q;
        alu_d       = alu_q;
        ext_d       = ext_q;
        sdata_d     = sdata_q;
        sim_end_d   = sim_end_q;
        is_load_d   = is_load_q;
        is_store_d  = is_store_q;
        cnt_d       = cnt_q;
        mem_error_d = mem_error_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opcode_d   = in_opcode;
                    twob_d     = in_twob;
                    regbyte_d  = in_regbyte;
                    rmbyte_d   = in_rmbyte;
                    alu_d      = in_alu_result;
                    ext_d      = in_alu_ext_result;
                    sdata_d    = in_store_data;
                    sim_end_d  = in_sim_end;
                    is_load_d  = in_is_load;
                    is_store_d = in_is_store;
                    timeout_d  = 1'b0;
                    state_d    = (in_is_load || in_is_store) ? ST_REQ : ST_OUT;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response arriving on the last allowed cycle still wins over the timeout.
                if (mem_resp_valid) begin
                    if (is_load_q) begin
                        alu_d = mem_resp_rdata;
                    end
                    state_d = ST_OUT;
                end else if (cnt_inc >= MAX_CNT) begin
                    cnt_d       = cnt_inc;
                    mem_error_d = 1'b1;
                    timeout_d   = 1'b1;
                    alu_d       = '0;
                    state_d     = ST_OUT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_OUT: begin
                if (wb_ready) begin
                    state_d = sim_end_q ? ST_HALT : ST_IDLE;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            twob_q      <= 1'b0;
            regbyte_q   <= '0;
            rmbyte_q    <= '0;
            alu_q       <= '0;
            ext_q       <= '0;
            sdata_q     <= '0;
            sim_end_q   <= 1'b0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            cnt_q       <= '0;
            mem_error_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            twob_q      <= twob_d;
            regbyte_q   <= regbyte_d;
            rmbyte_q    <= rmbyte_d;
            alu_q       <= alu_d;
            ext_q       <= ext_d;
            sdata_q     <= sdata_d;
            sim_end_q   <= sim_end_d;
            is_load_q   <= is_load_d;
            is_store_q  <= is_store_d;
            cnt_q       <= cnt_d;
            mem_error_q <= mem_error_d;
            timeout_q   <= timeout_d;
        end
    end

    assign in_ready              = (state_q == ST_IDLE);
    assign mem_req_valid         = (state_q == ST_REQ);
    assign mem_req_we            = is_store_q;
    assign mem_req_addr          = alu_q;
    assign mem_req_wdata         = sdata_q;
    assign wb_valid              = (state_q == ST_OUT);
    assign wb_alu_result         = alu_q;
    assign wb_alu_ext_result     = ext_q;
    assign wb_opcode             = opcode_q;
    assign wb_twob_opcode        = twob_q;
    assign wb_regbyte            = regbyte_q;
    assign wb_rmbyte             = rmbyte_q;
    assign wb_sim_end            = sim_end_q;
    assign store_memstage_active = (state_q == ST_OUT) && is_store_q && !timeout_q;
    assign mem_error             = mem_error_q;

endmodule

// File: tb/tb_mod_memstage.sv
// Directed bench for mod_memstage: pass-through, load, store, opcode classes,
// timeout, writeback backpressure, reset mid-transaction and halt.
module tb_mod_memstage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_opcode;
    logic        in_twob;
    logic [3:0]  in_regbyte;
    logic [3:0]  in_rmbyte;
    logic [63:0] in_alu_result;
    logic [63:0] in_alu_ext_result;
    logic [63:0] in_store_data;
    logic        in_sim_end;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_alu_result;
    logic [63:0] wb_alu_ext_result;
    logic [7:0]  wb_opcode;
    logic        wb_twob_opcode;
    logic [3:0]  wb_regbyte;
    logic [3:0]  wb_rmbyte;
    logic        wb_sim_end;
    logic        store_memstage_active;
    logic        mem_error;

    int tests_run;
    int tests_failed;

    mod_memstage #(.MAX_WAIT(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_opcode            (in_opcode),
        .in_twob              (in_twob),
        .in_regbyte           (in_regbyte),
        .in_rmbyte            (in_rmbyte),
        .in_alu_result        (in_alu_result),
        .in_alu_ext_result    (in_alu_ext_result),
        .in_store_data        (in_store_data),
        .in_sim_end           (in_sim_end),
        .mem_req_valid        (mem_req_valid),
        .mem_req_ready        (mem_req_ready),
        .mem_req_we           (mem_req_we),
        .mem_req_addr         (mem_req_addr),
        .mem_req_wdata        (mem_req_wdata),
        .mem_resp_valid       (mem_resp_valid),
        .mem_resp_rdata       (mem_resp_rdata),
        .wb_valid             (wb_valid),
        .wb_ready             (wb_ready),
        .wb_alu_result        (wb_alu_result),
        .wb_alu_ext_result    (wb_alu_ext_result),
        .wb_opcode            (wb_opcode),
        .wb_twob_opcode       (wb_twob_opcode),
        .wb_regbyte           (wb_regbyte),
        .wb_rmbyte            (wb_rmbyte),
        .wb_sim_end           (wb_sim_end),
        .store_memstage_active(store_memstage_active),
        .mem_error            (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so drives and samples sit away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] op, input logic twob, input logic [63:0] alu,
                           input logic [63:0] ext, input logic [63:0] sdata, input logic sim_end);
        in_valid          = 1'b1;
        in_opcode         = op;
        in_twob           = twob;
        in_alu_result     = alu;
        in_alu_ext_result = ext;
        in_store_data     = sdata;
        in_sim_end        = sim_end;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tests_run++;
        if ({wb_valid, mem_req_valid, store_memstage_active, mem_error} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {wb_valid, mem_req_valid, store_memstage_active, mem_error});
        end
        tests_run++;
        if (wb_alu_result !== 64'h0 || wb_opcode !== 8'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_payload: got %h/%h expected 0/0", wb_alu_result, wb_opcode);
        end
    endtask

    task automatic test_pass();
        present(8'h01, 1'b0, 64'h5, 64'h77, 64'h0, 1'b0);
        in_regbyte = 4'd3;
        in_rmbyte  = 4'd5;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (wb_valid !== 1'b1 || wb_alu_result !== 64'h5) begin
            tests_failed++;
            $display("[TB] FAIL pass_result: got valid=%b res=%h expected valid=1 res=5",
                     wb_valid, wb_alu_result);
        end
        tests_run++;
        if (wb_alu_ext_result !== 64'h77 || wb_opcode !== 8'h01 || wb_regbyte !== 4'd3 ||
            wb_rmbyte !== 4'd5 || wb_twob_opcode !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pass_fields: got ext=%h op=%h reg=%h rm=%h expected 77/01/3/5",
                     wb_alu_ext_result, wb_opcode, wb_regbyte, wb_rmbyte);
        end
        tests_run++;
        if (mem_req_valid !== 1'b0 || in_ready !== 1'b0 || store_memstage_active !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pass_ctrl: got req=%b rdy=%b st=%b expected 0/0/0",
                     mem_req_valid, in_ready, store_memstage_active);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pass_return: got rdy=%b wbv=%b expected 1/0", in_ready, wb_valid);
        end
    endtask

    task automatic test_load();
        present(8'd139, 1'b0, 64'h1000, 64'h11, 64'h1234, 1'b0);
        in_regbyte = 4'd1;
        in_rmbyte  = 4'd2;
        step();
        in_valid       = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hBAD;
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 64'h1000) begin
            tests_failed++;
            $display("[TB] FAIL load_req: got v=%b we=%b addr=%h expected 1/0/1000",
                     mem_req_valid, mem_req_we, mem_req_addr);
        end
        step();
        mem_resp_valid = 1'b0;
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000) begin
            tests_failed++;
            $display("[TB] FAIL load_req_hold: got v=%b addr=%h expected 1/1000",
                     mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        tests_run++;
        if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_wait: got req=%b wbv=%b expected 0/0", mem_req_valid, wb_valid);
        end
        step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hDEAD;
        step();
        mem_resp_valid = 1'b0;
        tests_run++;
        if (wb_valid !== 1'b1 || wb_alu_result !== 64'hDEAD || wb_alu_ext_result !== 64'h11) begin
            tests_failed++;
            $display("[TB] FAIL load_result: got v=%b res=%h ext=%h expected 1/dead/11",
                     wb_valid, wb_alu_result, wb_alu_ext_result);
        end
        tests_run++;
        if (store_memstage_active !== 1'b0 || mem_error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_flags: got st=%b err=%b expected 0/0",
                     store_memstage_active, mem_error);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
    endtask

    task automatic test_store();
        present(8'd137, 1'b0, 64'h2000, 64'h0, 64'hBEEF, 1'b0);
        mem_req_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_wdata !== 64'hBEEF ||
            mem_req_addr !== 64'h2000) begin
            tests_failed++;
            $display("[TB] FAIL store_req: got v=%b we=%b wd=%h addr=%h expected 1/1/beef/2000",
                     mem_req_valid, mem_req_we, mem_req_wdata, mem_req_addr);
        end
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h9999;
        step();
        mem_resp_valid = 1'b0;
        tests_run++;
        if (wb_valid !== 1'b1 || store_memstage_active !== 1'b1 || wb_alu_result !== 64'h2000) begin
            tests_failed++;
            $display("[TB] FAIL store_out: got v=%b st=%b res=%h expected 1/1/2000",
                     wb_valid, store_memstage_active, wb_alu_result);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        tests_run++;
        if (store_memstage_active !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL store_done: got st=%b rdy=%b expected 0/1",
                     store_memstage_active, in_ready);
        end
    endtask

    task automatic test_classify();
        logic [7:0] ops  [11];
        logic       twbs [11];
        logic [1:0] cls  [11];
        logic [63:0] exp_res;
        ops  = '{8'd88, 8'd95, 8'd195, 8'd96, 8'd80, 8'd87, 8'd232, 8'd255, 8'd139, 8'd79, 8'd138};
        twbs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        cls  = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 11; i++) begin
            present(ops[i], twbs[i], 64'h100 + 64'(i), 64'h0, 64'h0, 1'b0);
            step();
            in_valid = 1'b0;
            tests_run++;
            if (mem_req_valid !== (cls[i] != 2'd0) || wb_valid !== (cls[i] == 2'd0) ||
                (cls[i] != 2'd0 && mem_req_we !== (cls[i] == 2'd2))) begin
                tests_failed++;
                $display("[TB] FAIL classify_op%0d: got req=%b we=%b wbv=%b expected class %0d",
                         ops[i], mem_req_valid, mem_req_we, wb_valid, cls[i]);
            end
            if (cls[i] != 2'd0) begin
                mem_req_ready = 1'b1;
                step();
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 64'hD0 + 64'(i);
                step();
                mem_resp_valid = 1'b0;
            end
            exp_res = (cls[i] == 2'd1) ? 64'hD0 + 64'(i) : 64'h100 + 64'(i);
            tests_run++;
            if (wb_alu_result !== exp_res || store_memstage_active !== (cls[i] == 2'd2) ||
                wb_twob_opcode !== twbs[i]) begin
                tests_failed++;
                $display("[TB] FAIL classify_out_op%0d: got res=%h st=%b expected res=%h st=%b",
                         ops[i], wb_alu_result, store_memstage_active, exp_res, cls[i] == 2'd2);
            end
            wb_ready = 1'b1;
            step();
            wb_ready = 1'b0;
        end
    endtask

    task automatic test_timeout();
        present(8'd139, 1'b0, 64'h3000, 64'h0, 64'h0, 1'b0);
        mem_req_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        mem_req_ready = 1'b0;
        step();
        step();
        step();
        tests_run++;
        if (wb_valid !== 1'b0 || mem_error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_early: got wbv=%b err=%b after 3 wait cycles expected 0/0",
                     wb_valid, mem_error);
        end
        step();
        tests_run++;
        if (wb_valid !== 1'b1 || mem_error !== 1'b1 || wb_alu_result !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_hit: got wbv=%b err=%b res=%h expected 1/1/0",
                     wb_valid, mem_error, wb_alu_result);
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h55;
        step();
        mem_resp_valid = 1'b0;
        tests_run++;
        if (wb_alu_result !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_late_resp: got res=%h expected 0", wb_alu_result);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        tests_run++;
        if (mem_error !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_sticky: got err=%b expected 1", mem_error);
        end
        present(8'd137, 1'b0, 64'h4000, 64'h0, 64'h77, 1'b0);
        mem_req_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        tests_run++;
        if (wb_valid !== 1'b1 || store_memstage_active !== 1'b0 || wb_alu_result !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_store: got wbv=%b st=%b res=%h expected 1/0/0",
                     wb_valid, store_memstage_active, wb_alu_result);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        present(8'h02, 1'b0, 64'hABCD, 64'h0, 64'h0, 1'b0);
        step();
        present(8'h03, 1'b0, 64'h1111, 64'h0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (wb_valid !== 1'b1 || wb_alu_result !== 64'hABCD || wb_opcode !== 8'h02 ||
                in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL backpressure_c%0d: got wbv=%b res=%h op=%h rdy=%b expected 1/abcd/02/0",
                         i, wb_valid, wb_alu_result, wb_opcode, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        tests_run++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_release: got wbv=%b rdy=%b expected 0/1", wb_valid, in_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        present(8'd139, 1'b0, 64'h5000, 64'h0, 64'h0, 1'b0);
        mem_req_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        mem_req_ready = 1'b0;
        reset = 1'b0;
        step();
        tests_run++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || mem_error !== 1'b0 || wb_alu_result !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wait: got rdy=%b wbv=%b err=%b res=%h expected 1/0/0/0",
                     in_ready, wb_valid, mem_error, wb_alu_result);
        end
        reset          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hF00D;
        step();
        mem_resp_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || wb_alu_result !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_stale_resp: got rdy=%b wbv=%b res=%h expected 1/0/0",
                     in_ready, wb_valid, wb_alu_result);
        end
    endtask

    task automatic test_sim_end();
        present(8'h04, 1'b0, 64'h9, 64'h0, 64'h0, 1'b1);
        step();
        in_valid = 1'b0;
        tests_run++;
        if (wb_valid !== 1'b1 || wb_sim_end !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sim_end_out: got wbv=%b end=%b expected 1/1", wb_valid, wb_sim_end);
        end
        wb_ready = 1'b1;
        step();
        present(8'h05, 1'b0, 64'h1, 64'h0, 64'h0, 1'b0);
        step();
        step();
        tests_run++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL halt_hold: got rdy=%b wbv=%b req=%b expected 0/0/0",
                     in_ready, wb_valid, mem_req_valid);
        end
        in_valid = 1'b0;
        wb_ready = 1'b0;
        reset    = 1'b0;
        step();
        reset = 1'b1;
        tests_run++;
        if (in_ready !== 1'b1 || wb_sim_end !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL halt_reset: got rdy=%b end=%b expected 1/0", in_ready, wb_sim_end);
        end
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        reset             = 1'b0;
        in_valid          = 1'b0;
        in_opcode         = '0;
        in_twob           = 1'b0;
        in_regbyte        = '0;
        in_rmbyte         = '0;
        in_alu_result     = '0;
        in_alu_ext_result = '0;
        in_store_data     = '0;
        in_sim_end        = 1'b0;
        mem_req_ready     = 1'b0;
        mem_resp_valid    = 1'b0;
        mem_resp_rdata    = '0;
        wb_ready          = 1'b0;
        test_reset();
        test_pass();
        test_load();
        test_store();
        test_classify();
        test_timeout();
        test_backpressure();
        test_reset_in_wait();
        test_sim_end();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mod_memstage.md
MOD_MEMSTAGE -- requirements
Module: mod_memstage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255, giving the cycles allowed in WAIT before timeout.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port in_valid  in  1  execute result valid.
REQ-005 SHALL have port in_ready  out  1  stage accepts execute result.
REQ-006 SHALL have port in_opcode  in  8  primary opcode.
REQ-007 SHALL have port in_twob  in  1  two-byte opcode flag.
REQ-008 SHALL have port in_regbyte  in  4  reg-field register index.
REQ-009 SHALL have port in_rmbyte  in  4  rm-field register index.
REQ-010 SHALL have port in_alu_result  in  64  ALU result or effective address.
REQ-011 SHALL have port in_alu_ext_result  in  64  extended ALU result.
REQ-012 SHALL have port in_store_data  in  64  store data.
REQ-013 SHALL have port in_sim_end  in  1  end-of-simulation marker.
REQ-014 SHALL have port mem_req_valid  out  1  memory request valid.
REQ-015 SHALL have port mem_req_ready  in  1  memory accepts request.
REQ-016 SHALL have port mem_req_we  out  1  1=write, 0=read.
REQ-017 SHALL have port mem_req_addr  out  64  request address.
REQ-018 SHALL have port mem_req_wdata  out  64  write data.
REQ-019 SHALL have port mem_resp_valid  in  1  read data or write acknowledge.
REQ-020 SHALL have port mem_resp_rdata  in  64  read data.
REQ-021 SHALL have port wb_valid  out  1  EX_WB payload valid to writeback.
REQ-022 SHALL have port wb_ready  in  1  writeback consumes payload.
REQ-023 SHALL have ports wb_alu_result/wb_alu_ext_result  out  64 each  EX_WB result fields.
REQ-024 SHALL have ports wb_opcode (8), wb_twob_opcode (1), wb_regbyte (4), wb_rmbyte (4), wb_sim_end (1)  out  EX_WB control fields.
REQ-025 SHALL have port store_memstage_active  out  1  completed store presented to writeback.
REQ-026 SHALL have port mem_error  out  1  sticky memory timeout flag.

Function
REQ-027 SHALL implement FSM IDLE, REQ, WAIT, OUT, HALT; in_ready=1 only in IDLE.
REQ-028 SHALL classify a captured op as LOAD (twob=0 and opcode 139, 88..95, or 195), STORE (twob=0 and opcode 137, 80..87, 232, or 255), otherwise PASS.
REQ-029 SHALL, on IDLE with in_valid, capture all in_* fields, then go to OUT for PASS (latency 1) or to REQ for LOAD/STORE.
REQ-030 SHALL in REQ hold mem_req_valid=1, addr=captured alu_result, we=STORE, wdata=captured store_data stable until mem_req_ready, then go to WAIT.
REQ-031 SHALL in WAIT sample mem_resp_valid only; LOAD replaces wb_alu_result with mem_resp_rdata; STORE keeps alu_result; then go to OUT.
REQ-032 SHALL count WAIT cycles in an 8-bit+ counter cleared on WAIT entry; at MAX_WAIT without a response it sets mem_error=1, forces wb_alu_result=0, and goes to OUT.
REQ-033 SHALL in OUT hold wb_valid=1 with stable payload until wb_ready, then go to IDLE, or to HALT if wb_sim_end=1.
REQ-034 SHALL drive store_memstage_active=1 exactly while in OUT for a STORE that completed without timeout.
REQ-035 SHALL ignore mem_resp_valid outside WAIT; the memory guarantees a response no earlier than the cycle after the request handshake.
REQ-036 SHALL in HALT hold in_ready=0, wb_valid=0, mem_req_valid=0 until reset.
REQ-037 SHALL pass ext_result, opcode, twob, regbyte, rmbyte, and sim_end unchanged to wb_*.

Reset
REQ-038 SHALL, when reset=0 at a clock edge in any state, go to IDLE and clear wb_valid, mem_req_valid, store_memstage_active, mem_error, the counter, and all wb_* fields to 0; any in-flight request is abandoned.

Verification
REQ-039 SHALL pass PASS op: opcode 0x01, alu_result 0x5 -> wb_valid one cycle after accept, wb_alu_result=0x5.
REQ-040 SHALL pass LOAD: opcode 139, addr 0x1000, mem_req_ready after 2 cycles, rdata 0xDEAD -> mem_req_we=0, wb_alu_result=0xDEAD.
REQ-041 SHALL pass STORE: opcode 137, addr 0x2000, data 0xBEEF -> mem_req_we=1, wdata=0xBEEF, store_memstage_active=1 with wb_valid.
REQ-042 SHALL pass timeout: LOAD with no response, MAX_WAIT=4 -> mem_error=1 after 4 WAIT cycles, wb_alu_result=0.
REQ-043 SHALL pass backpressure and reset: wb_ready=0 for 3 cycles holds payload; reset=0 during WAIT -> IDLE next edge, stale response ignored.
